// File: rtl/run_seq_pkg.sv
// ----------------------------------------------------------------------------
// run_seq_pkg
//
// Purpose:
//    Shared type definitions for the run sequencer. Only the state encoding
//    lives here; every size (PC width, memory address width, cycle budget,
//    counter width) comes from the run_sequencer module parameters so that
//    several differently-sized sequencers can coexist in one build.
//
// Contents:
//    seq_state_t  - FSM state encoding (IDLE, CLEAR, BOOT, RUN, DONE)
// ----------------------------------------------------------------------------
package run_seq_pkg;

    // Sequencer phases, in the order a normal run walks through them.
    //    IDLE  : core held in reset, waiting for a request
    //    CLEAR : core held in reset while data memory is zero-filled
    //    BOOT  : core held in reset for a fixed number of cycles
    //    RUN   : core released and advancing
    //    DONE  : core frozen (not reset) so its memory stays readable
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        BOOT  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage : run_seq_pkg

// File: rtl/run_sequencer.sv
// ----------------------------------------------------------------------------
// run_sequencer
//
// Purpose:
//    Start/stop controller for the processor core. It sits between the
//    bench-side req/done handshake and the core. A rising edge on req
//    optionally zero-fills data memory, then holds the core in reset for a
//    fixed number of cycles, then releases it. The core then runs until it
//    halts (PC reaches HALT_PC or halt_i is raised) or a cycle budget runs
//    out. The sequencer then reports done, the number of RUN cycles and
//    whether the run ended by timeout.
//
// Parameters:
//    D        - program counter width
//    HALT_PC  - prog_ctr value that marks the end of the program
//    MEM_AW   - data memory address width; clear walks 2**MEM_AW words
//    CLR_MEM  - 1 = zero-fill data memory before each run
//    RST_CYC  - cycles core_rst is held in BOOT (>= 1, <= 2**MEM_AW)
//    MAX_CYC  - RUN-cycle budget before timeout (>= 2)
//    CW       - cycle counter width; must be able to hold MAX_CYC
//
// Ports:
//    clk       in   1       system clock
//    reset     in   1       synchronous, active-high reset
//    req       in   1       run request, acted on at its rising edge only
//    prog_ctr  in   D       core program counter
//    halt_i    in   1       explicit halt from the control decoder
//    core_rst  out  1       synchronous reset to PC/core
//    core_en   out  1       core advance enable
//    clr_we    out  1       data-memory write enable during clear
//    clr_addr  out  MEM_AW  data-memory address during clear (data is 0)
//    busy      out  1       high in CLEAR, BOOT and RUN
//    done      out  1       level, high in DONE
//    timeout   out  1       run ended by budget rather than halt
//    cycles    out  CW      RUN cycles of the last run, saturating
//
// All outputs are registers loaded from the next-state decode, so there is
// no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int D       = 12,
    parameter int HALT_PC = 128,
    parameter int MEM_AW  = 8,
    parameter bit CLR_MEM = 1'b0,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 4096,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [D-1:0]      prog_ctr,
    input  logic              halt_i,
    output logic              core_rst,
    output logic              core_en,
    output logic              clr_we,
    output logic [MEM_AW-1:0] clr_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CW-1:0]     cycles
);

    // Terminal values for the shared step counter and the run budget,
    // pre-sized so every comparison below is width-matched.
    localparam logic [MEM_AW-1:0] CLR_LAST  = {MEM_AW{1'b1}};
    localparam logic [MEM_AW-1:0] BOOT_LAST = MEM_AW'(RST_CYC - 1);
    localparam logic [CW-1:0]     RUN_LAST  = CW'(MAX_CYC - 1);
    localparam logic [D-1:0]      HALT_VAL  = D'(HALT_PC);

    // State and datapath registers with their next-state values.
    seq_state_t        state_q,   state_d;
    logic [MEM_AW-1:0] cnt_q,     cnt_d;
    logic [CW-1:0]     cycles_q,  cycles_d;
    logic              timeout_q, timeout_d;
    logic              req_q;

    // Registered output copies.
    logic              core_rst_q;
    logic              core_en_q;
    logic              clr_we_q;
    logic              busy_q;
    logic              done_q;

    logic              start;
    logic              halt;
    logic              budget_hit;

    // A run request is a 0->1 transition of req. Holding req high therefore
    // never retriggers a run, which lets the bench leave req asserted while
    // it reads results in DONE.
    assign start = req & ~req_q;

    // The core is finished either when it fetches the halt address or when
    // the decoder flags an explicit halt.
    assign halt = (prog_ctr == HALT_VAL) | halt_i;

    // cycles_q counts completed RUN cycles, so the current RUN cycle is
    // cycles_q+1; the budget is exhausted in the cycle where that equals
    // MAX_CYC.
    assign budget_hit = (cycles_q == RUN_LAST);

    // Next-state logic. The one step counter doubles as the clear address in
    // CLEAR and as the reset-hold timer in BOOT; it is always zero on entry
    // to either state. A new run clears cycles and timeout on the way out of
    // IDLE or DONE so the results of the previous run stay visible until
    // then. In RUN, halt is tested before the budget so a halt landing on
    // the last budgeted cycle still reports a clean finish.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d     = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = CLR_MEM ? CLEAR : BOOT;
                end
            end

            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = BOOT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (cycles_q != {CW{1'b1}}) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (halt) begin
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (budget_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register plus registered Moore outputs. Outputs are decoded from
    // state_d so they line up with state_q in the same cycle while still
    // coming straight out of flops. The core stays in reset everywhere
    // except RUN and DONE; in DONE it is merely frozen so its memories can
    // be inspected.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            req_q      <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            clr_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            req_q      <= req;
            core_rst_q <= (state_d != RUN) && (state_d != DONE);
            core_en_q  <= (state_d == RUN);
            clr_we_q   <= (state_d == CLEAR);
            busy_q     <= (state_d == CLEAR) || (state_d == BOOT) ||
                          (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

    // Drive the ports from their registers.
    assign core_rst = core_rst_q;
    assign core_en  = core_en_q;
    assign clr_we   = clr_we_q;
    assign clr_addr = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

endmodule : run_sequencer

// File: tb/tb_run_sequencer.sv
// ----------------------------------------------------------------------------
// tb_run_sequencer
//
// Directed bench for run_sequencer. Two instances share clock and reset:
//    dutA - no memory clear, 2-cycle boot, 16-cycle budget
//    dutB - memory clear over 8 words, 2-cycle boot, 16-cycle budget
// Inputs change 1 time unit after a rising edge and outputs are read at the
// same point, so every observation sits well clear of the active edge.
// ----------------------------------------------------------------------------
module tb_run_sequencer;

    logic        clk;
    logic        reset;

    logic        aReq;
    logic [11:0] aPc;
    logic        aHalt;
    logic        aCoreRst, aCoreEn, aClrWe, aBusy, aDone, aTimeout;
    logic [7:0]  aClrAddr;
    logic [15:0] aCycles;

    logic        bReq;
    logic [11:0] bPc;
    logic        bHalt;
    logic        bCoreRst, bCoreEn, bClrWe, bBusy, bDone, bTimeout;
    logic [2:0]  bClrAddr;
    logic [15:0] bCycles;

    int checkCount;
    int errorCount;

    run_sequencer #(
        .D(12), .HALT_PC(128), .MEM_AW(8), .CLR_MEM(1'b0),
        .RST_CYC(2), .MAX_CYC(16), .CW(16)
    ) dutA (
        .clk(clk), .reset(reset), .req(aReq), .prog_ctr(aPc), .halt_i(aHalt),
        .core_rst(aCoreRst), .core_en(aCoreEn), .clr_we(aClrWe),
        .clr_addr(aClrAddr), .busy(aBusy), .done(aDone),
        .timeout(aTimeout), .cycles(aCycles)
    );

    run_sequencer #(
        .D(12), .HALT_PC(128), .MEM_AW(3), .CLR_MEM(1'b1),
        .RST_CYC(2), .MAX_CYC(16), .CW(16)
    ) dutB (
        .clk(clk), .reset(reset), .req(bReq), .prog_ctr(bPc), .halt_i(bHalt),
        .core_rst(bCoreRst), .core_en(bCoreEn), .clr_we(bClrWe),
        .clr_addr(bClrAddr), .busy(bBusy), .done(bDone),
        .timeout(bTimeout), .cycles(bCycles)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check every dutA output against the idle/reset values.
    task automatic checkIdleA(input string tag);
        checkOutput({tag, ".core_rst"}, 32'(aCoreRst), 32'd1);
        checkOutput({tag, ".core_en"},  32'(aCoreEn),  32'd0);
        checkOutput({tag, ".clr_we"},   32'(aClrWe),   32'd0);
        checkOutput({tag, ".clr_addr"}, 32'(aClrAddr), 32'd0);
        checkOutput({tag, ".busy"},     32'(aBusy),    32'd0);
        checkOutput({tag, ".done"},     32'(aDone),    32'd0);
        checkOutput({tag, ".timeout"},  32'(aTimeout), 32'd0);
        checkOutput({tag, ".cycles"},   32'(aCycles),  32'd0);
    endtask

    // Main directed sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        aReq = 1'b0; aPc = '0; aHalt = 1'b0;
        bReq = 1'b0; bPc = '0; bHalt = 1'b0;
        applyStimulus(2);
        reset = 1'b0;

        // Reset state.
        checkIdleA("reset");
        checkOutput("resetB.core_rst", 32'(bCoreRst), 32'd1);
        checkOutput("resetB.clr_we",   32'(bClrWe),   32'd0);

        // Test 1: boot latency and halt by PC.
        aReq = 1'b1;
        applyStimulus(1);
        aReq = 1'b0;
        checkOutput("t1.boot1.core_rst", 32'(aCoreRst), 32'd1);
        checkOutput("t1.boot1.core_en",  32'(aCoreEn),  32'd0);
        checkOutput("t1.boot1.busy",     32'(aBusy),    32'd1);
        applyStimulus(1);
        checkOutput("t1.boot2.core_rst", 32'(aCoreRst), 32'd1);
        checkOutput("t1.boot2.core_en",  32'(aCoreEn),  32'd0);
        applyStimulus(1);
        checkOutput("t1.run1.core_rst",  32'(aCoreRst), 32'd0);
        checkOutput("t1.run1.core_en",   32'(aCoreEn),  32'd1);
        applyStimulus(2);
        aReq = 1'b1;
        applyStimulus(1);
        aReq = 1'b0;
        applyStimulus(1);
        checkOutput("t1.ignore.core_en", 32'(aCoreEn),  32'd1);
        checkOutput("t1.ignore.cycles",  32'(aCycles),  32'd4);
        applyStimulus(5);
        checkOutput("t1.run10.done",     32'(aDone),    32'd0);
        aPc = 12'd128;
        applyStimulus(1);
        aPc = 12'd0;
        checkOutput("t1.done",           32'(aDone),    32'd1);
        checkOutput("t1.cycles",         32'(aCycles),  32'd10);
        checkOutput("t1.timeout",        32'(aTimeout), 32'd0);
        checkOutput("t1.core_rst",       32'(aCoreRst), 32'd0);
        checkOutput("t1.busy",           32'(aBusy),    32'd0);

        // Test 3: budget expiry, req held high from start through DONE.
        aReq = 1'b1;
        applyStimulus(1);
        checkOutput("t3.boot1.cycles",   32'(aCycles),  32'd0);
        checkOutput("t3.boot1.done",     32'(aDone),    32'd0);
        applyStimulus(2);
        checkOutput("t3.run1.core_en",   32'(aCoreEn),  32'd1);
        applyStimulus(15);
        checkOutput("t3.run16.done",     32'(aDone),    32'd0);
        applyStimulus(1);
        checkOutput("t3.done",           32'(aDone),    32'd1);
        checkOutput("t3.timeout",        32'(aTimeout), 32'd1);
        checkOutput("t3.cycles",         32'(aCycles),  32'd16);
        checkOutput("t3.core_en",        32'(aCoreEn),  32'd0);

        // Test 5: held req does not restart; a fresh rising edge does.
        applyStimulus(3);
        checkOutput("t5.hold.done",      32'(aDone),    32'd1);
        checkOutput("t5.hold.busy",      32'(aBusy),    32'd0);
        checkOutput("t5.hold.cycles",    32'(aCycles),  32'd16);
        aReq = 1'b0;
        applyStimulus(1);
        aReq = 1'b1;
        applyStimulus(1);
        aReq = 1'b0;
        checkOutput("t5.restart.busy",     32'(aBusy),    32'd1);
        checkOutput("t5.restart.done",     32'(aDone),    32'd0);
        checkOutput("t5.restart.core_rst", 32'(aCoreRst), 32'd1);
        checkOutput("t5.restart.cycles",   32'(aCycles),  32'd0);
        checkOutput("t5.restart.timeout",  32'(aTimeout), 32'd0);

        // Test 4: halt_i on the last budgeted cycle beats the timeout.
        applyStimulus(2);
        applyStimulus(15);
        checkOutput("t4.run16.core_en",  32'(aCoreEn),  32'd1);
        aHalt = 1'b1;
        applyStimulus(1);
        aHalt = 1'b0;
        checkOutput("t4.done",           32'(aDone),    32'd1);
        checkOutput("t4.timeout",        32'(aTimeout), 32'd0);
        checkOutput("t4.cycles",         32'(aCycles),  32'd16);

        // Test 6: reset in RUN cycle 5 returns to idle at the next edge.
        aReq = 1'b1;
        applyStimulus(1);
        aReq = 1'b0;
        applyStimulus(6);
        checkOutput("t6.run5.core_en",   32'(aCoreEn),  32'd1);
        checkOutput("t6.run5.cycles",    32'(aCycles),  32'd4);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkIdleA("t6.reset");

        // Test 2: memory clear walks all 8 addresses, then boots.
        bReq = 1'b1;
        applyStimulus(1);
        bReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2.clr%0d.clr_we", i),   32'(bClrWe),   32'd1);
            checkOutput($sformatf("t2.clr%0d.clr_addr", i), 32'(bClrAddr), 32'(i));
            checkOutput($sformatf("t2.clr%0d.busy", i),     32'(bBusy),    32'd1);
            checkOutput($sformatf("t2.clr%0d.core_rst", i), 32'(bCoreRst), 32'd1);
            applyStimulus(1);
        end
        checkOutput("t2.boot1.clr_we",   32'(bClrWe),   32'd0);
        checkOutput("t2.boot1.busy",     32'(bBusy),    32'd1);
        checkOutput("t2.boot1.core_rst", 32'(bCoreRst), 32'd1);
        checkOutput("t2.boot1.core_en",  32'(bCoreEn),  32'd0);
        applyStimulus(1);
        checkOutput("t2.boot2.busy",     32'(bBusy),    32'd1);
        checkOutput("t2.boot2.core_en",  32'(bCoreEn),  32'd0);
        applyStimulus(1);
        checkOutput("t2.run1.core_en",   32'(bCoreEn),  32'd1);
        checkOutput("t2.run1.core_rst",  32'(bCoreRst), 32'd0);
        checkOutput("t2.run1.busy",      32'(bBusy),    32'd1);
        bPc = 12'd128;
        applyStimulus(1);
        bPc = 12'd0;
        checkOutput("t2.done",           32'(bDone),    32'd1);
        checkOutput("t2.cycles",         32'(bCycles),  32'd1);
        checkOutput("t2.busy",           32'(bBusy),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule : tb_run_sequencer
